exec_unit_p: RTL and testbench

EXEC_UNIT_P -- requirements
Module: exec_unit_p

---
 rtl/exec_unit_p_pkg.sv | 32 +++
 rtl/exec_unit_p_if.sv | 38 +++
 rtl/exec_fwd_mux.sv | 32 +++
 rtl/exec_unit_p.sv | 200 ++++++++++++++++++++
 tb/tb_exec_unit_p.sv | 454 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/exec_unit_p_pkg.sv
// Shared encodings for the execute stage: ALU op classes, R-type function codes,
// multiply FSM states and control-bundle bit positions.
package exec_unit_p_pkg;

    typedef enum logic [1:0] {
        AluAdd   = 2'b00,
        AluSub   = 2'b01,
        AluRtype = 2'b10,
        AluRsvd  = 2'b11
    } alu_op_e;

    localparam logic [5:0] FunctAdd = 6'd0;
    localparam logic [5:0] FunctSub = 6'd1;
    localparam logic [5:0] FunctMul = 6'd2;
    localparam logic [5:0] FunctAnd = 6'd3;
    localparam logic [5:0] FunctOr  = 6'd4;
    localparam logic [5:0] FunctSlt = 6'd5;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StMulBusy = 2'd1,
        StMulDone = 2'd2
    } state_e;

    // ctrl_in = {mem_read, mem_write, reg_write, mem_to_reg}
    localparam int unsigned CtrlW        = 4;
    localparam int unsigned CtrlMemRead  = 3;
    localparam int unsigned CtrlMemWrite = 2;
    localparam int unsigned CtrlRegWrite = 1;
    localparam int unsigned CtrlMemToReg = 0;

endpackage

// File: rtl/exec_unit_p_if.sv
// ID/EX input bundle, forwarding sources and EX/DM output bundle of the execute stage.
interface exec_unit_p_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 5
);
    logic              in_valid, stall_in, flush;
    logic [1:0]        alu_op;
    logic [5:0]        funct;
    logic              alu_src, reg_dst, branch;
    logic [3:0]        ctrl_in;
    logic [DATA_W-1:0] pc, rs_data, rt_data, imm;
    logic [REG_AW-1:0] rs_addr, rt_addr, rd_addr;
    logic              exdm_reg_write, dmwb_reg_write;
    logic [REG_AW-1:0] exdm_rd, dmwb_rd;
    logic [DATA_W-1:0] exdm_result, dmwb_result;

    logic              busy, out_valid, zero, branch_taken;
    logic [DATA_W-1:0] result, store_data, branch_target;
    logic [REG_AW-1:0] rd_out;
    logic [3:0]        ctrl_out;

    modport master (
        output in_valid, stall_in, flush, alu_op, funct, alu_src, reg_dst, branch, ctrl_in,
               pc, rs_data, rt_data, imm, rs_addr, rt_addr, rd_addr,
               exdm_reg_write, dmwb_reg_write, exdm_rd, dmwb_rd, exdm_result, dmwb_result,
        input  busy, out_valid, zero, branch_taken, result, store_data, branch_target,
               rd_out, ctrl_out
    );

    modport slave (
        input  in_valid, stall_in, flush, alu_op, funct, alu_src, reg_dst, branch, ctrl_in,
               pc, rs_data, rt_data, imm, rs_addr, rt_addr, rd_addr,
               exdm_reg_write, dmwb_reg_write, exdm_rd, dmwb_rd, exdm_result, dmwb_result,
        output busy, out_valid, zero, branch_taken, result, store_data, branch_target,
               rd_out, ctrl_out
    );

endinterface

// File: rtl/exec_fwd_mux.sv
// Operand forwarding select: EX/DM result beats DM/WB result beats register-file value.
module exec_fwd_mux #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 5
) (
    input  logic [REG_AW-1:0] src_addr_i,
    input  logic [DATA_W-1:0] reg_data_i,
    input  logic              exdm_reg_write_i,
    input  logic [REG_AW-1:0] exdm_rd_i,
    input  logic [DATA_W-1:0] exdm_result_i,
    input  logic              dmwb_reg_write_i,
    input  logic [REG_AW-1:0] dmwb_rd_i,
    input  logic [DATA_W-1:0] dmwb_result_i,
    output logic [DATA_W-1:0] fwd_data_o
);

    logic exdm_hit, dmwb_hit;

    // Register zero is hard-wired, so a write "to" it never forwards.
    assign exdm_hit = exdm_reg_write_i && (exdm_rd_i == src_addr_i) && (src_addr_i != '0);
    assign dmwb_hit = dmwb_reg_write_i && (dmwb_rd_i == src_addr_i) && (src_addr_i != '0);

    always_comb begin
        fwd_data_o = reg_data_i;
        if (exdm_hit) begin
            fwd_data_o = exdm_result_i;
        end else if (dmwb_hit) begin
            fwd_data_o = dmwb_result_i;
        end
    end

endmodule

// File: rtl/exec_unit_p.sv
// Pipeline execute stage: forwarded ALU ops in one cycle, multiply through a small
// busy/done FSM, branch resolution, with stall, flush and synchronous reset.
module exec_unit_p
    import exec_unit_p_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned REG_AW  = 5,
    parameter int unsigned MUL_LAT = 3
) (
    input logic         clk,
    input logic         reset,
    exec_unit_p_if.slave bus
);

    localparam bit         MulMulti = (MUL_LAT > 1);
    localparam logic [2:0] CntLast  = 3'((MUL_LAT > 1) ? MUL_LAT - 2 : 0);

    logic [DATA_W-1:0] op_a, rt_fwd, op_b, alu_res;
    logic              alu_ok, is_mul, cmp_zero;
    logic [3:0]        ctrl_eff;
    alu_op_e           op;

    exec_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_a (
        .src_addr_i       (bus.rs_addr),
        .reg_data_i       (bus.rs_data),
        .exdm_reg_write_i (bus.exdm_reg_write),
        .exdm_rd_i        (bus.exdm_rd),
        .exdm_result_i    (bus.exdm_result),
        .dmwb_reg_write_i (bus.dmwb_reg_write),
        .dmwb_rd_i        (bus.dmwb_rd),
        .dmwb_result_i    (bus.dmwb_result),
        .fwd_data_o       (op_a)
    );

    exec_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_b (
        .src_addr_i       (bus.rt_addr),
        .reg_data_i       (bus.rt_data),
        .exdm_reg_write_i (bus.exdm_reg_write),
        .exdm_rd_i        (bus.exdm_rd),
        .exdm_result_i    (bus.exdm_result),
        .dmwb_reg_write_i (bus.dmwb_reg_write),
        .dmwb_rd_i        (bus.dmwb_rd),
        .dmwb_result_i    (bus.dmwb_result),
        .fwd_data_o       (rt_fwd)
    );

    assign op       = alu_op_e'(bus.alu_op);
    assign op_b     = (bus.alu_src || op == AluAdd) ? bus.imm : rt_fwd;
    assign cmp_zero = (op_a == op_b);

    always_comb begin
        alu_res = '0;
        alu_ok  = 1'b1;
        is_mul  = 1'b0;
        unique case (op)
            AluAdd:   alu_res = op_a + op_b;
            AluSub:   alu_res = op_a - op_b;
            AluRtype: begin
                case (bus.funct)
                    FunctAdd: alu_res = op_a + op_b;
                    FunctSub: alu_res = op_a - op_b;
                    FunctMul: begin
                        alu_res = op_a * op_b;
                        is_mul  = 1'b1;
                    end
                    FunctAnd: alu_res = op_a & op_b;
                    FunctOr:  alu_res = op_a | op_b;
                    FunctSlt: alu_res = {{(DATA_W-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
                    default:  alu_ok = 1'b0;
                endcase
            end
            AluRsvd:  alu_ok = 1'b0;
        endcase
        ctrl_eff = bus.ctrl_in;
        if (!alu_ok) begin
            ctrl_eff[CtrlMemWrite] = 1'b0;
            ctrl_eff[CtrlRegWrite] = 1'b0;
        end
    end

    state_e            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] mul_a_q, mul_a_d, mul_b_q, mul_b_d;
    logic [3:0]        mul_ctrl_q, mul_ctrl_d;
    logic              valid_q, valid_d, zero_q, zero_d, taken_q, taken_d;
    logic [DATA_W-1:0] result_q, result_d, store_q, store_d, target_q, target_d;
    logic [REG_AW-1:0] rd_q, rd_d;
    logic [3:0]        ctrl_q, ctrl_d;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mul_a_d    = mul_a_q;
        mul_b_d    = mul_b_q;
        mul_ctrl_d = mul_ctrl_q;
        valid_d    = valid_q;
        zero_d     = zero_q;
        taken_d    = taken_q;
        result_d   = result_q;
        store_d    = store_q;
        target_d   = target_q;
        rd_d       = rd_q;
        ctrl_d     = ctrl_q;

        // The multiply latency counter keeps running under stall and saturates.
        if (state_q == StMulBusy && cnt_q != CntLast) begin
            cnt_d = cnt_q + 3'd1;
        end

        if (bus.flush) begin
            state_d = StIdle;
            cnt_d   = '0;
            valid_d = 1'b0;
            ctrl_d  = '0;
            taken_d = 1'b0;
        end else if (!bus.stall_in) begin
            unique case (state_q)
                StIdle: begin
                    valid_d  = bus.in_valid;
                    ctrl_d   = bus.in_valid ? ctrl_eff : 4'b0000;
                    taken_d  = bus.branch & cmp_zero & bus.in_valid;
                    zero_d   = cmp_zero;
                    result_d = alu_res;
                    store_d  = rt_fwd;
                    target_d = bus.pc + bus.imm;
                    rd_d     = bus.reg_dst ? bus.rd_addr : bus.rt_addr;
                    if (bus.in_valid && is_mul && MulMulti) begin
                        state_d    = StMulBusy;
                        cnt_d      = '0;
                        valid_d    = 1'b0;
                        ctrl_d     = '0;
                        taken_d    = 1'b0;
                        mul_a_d    = op_a;
                        mul_b_d    = op_b;
                        mul_ctrl_d = ctrl_eff;
                    end
                end
                StMulBusy: begin
                    if (cnt_q == CntLast) begin
                        state_d  = StMulDone;
                        cnt_d    = '0;
                        valid_d  = 1'b1;
                        result_d = mul_a_q * mul_b_q;
                        ctrl_d   = mul_ctrl_q;
                    end
                end
                StMulDone: begin
                    state_d = StIdle;
                    valid_d = 1'b0;
                    ctrl_d  = '0;
                    taken_d = 1'b0;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            mul_a_q    <= '0;
            mul_b_q    <= '0;
            mul_ctrl_q <= '0;
            valid_q    <= 1'b0;
            zero_q     <= 1'b0;
            taken_q    <= 1'b0;
            result_q   <= '0;
            store_q    <= '0;
            target_q   <= '0;
            rd_q       <= '0;
            ctrl_q     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mul_a_q    <= mul_a_d;
            mul_b_q    <= mul_b_d;
            mul_ctrl_q <= mul_ctrl_d;
            valid_q    <= valid_d;
            zero_q     <= zero_d;
            taken_q    <= taken_d;
            result_q   <= result_d;
            store_q    <= store_d;
            target_q   <= target_d;
            rd_q       <= rd_d;
            ctrl_q     <= ctrl_d;
        end
    end

    assign bus.busy          = (state_q != StIdle);
    assign bus.out_valid     = valid_q;
    assign bus.zero          = zero_q;
    assign bus.branch_taken  = taken_q;
    assign bus.result        = result_q;
    assign bus.store_data    = store_q;
    assign bus.branch_target = target_q;
    assign bus.rd_out        = rd_q;
    assign bus.ctrl_out      = ctrl_q;

endmodule

// File: tb/tb_exec_unit_p.sv
// Self-checking bench for exec_unit_p: directed scenarios plus randomized ALU traffic
// compared against an arithmetic reference model.
module tb_exec_unit_p;
    import exec_unit_p_pkg::*;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned REG_AW  = 5;
    localparam int unsigned MUL_LAT = 3;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    exec_unit_p_if #(.DATA_W(DATA_W), .REG_AW(REG_AW)) bus ();

    exec_unit_p #(.DATA_W(DATA_W), .REG_AW(REG_AW), .MUL_LAT(MUL_LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        bus.in_valid = 0; bus.stall_in = 0; bus.flush = 0; bus.alu_op = 0; bus.funct = 0;
        bus.alu_src = 0; bus.reg_dst = 0; bus.branch = 0; bus.ctrl_in = 0; bus.pc = 0;
        bus.rs_data = 0; bus.rt_data = 0; bus.imm = 0; bus.rs_addr = 0; bus.rt_addr = 0;
        bus.rd_addr = 0; bus.exdm_reg_write = 0; bus.dmwb_reg_write = 0; bus.exdm_rd = 0;
        bus.dmwb_rd = 0; bus.exdm_result = 0; bus.dmwb_result = 0;
    endtask

    task automatic set_instr(input logic [1:0] op, input logic [5:0] fn, input logic src,
                             input logic [31:0] rs, input logic [31:0] rt,
                             input logic [31:0] im);
        clear_inputs();
        bus.in_valid = 1; bus.alu_op = op; bus.funct = fn; bus.alu_src = src;
        bus.rs_data = rs; bus.rt_data = rt; bus.imm = im;
        bus.rs_addr = 5'd1; bus.rt_addr = 5'd2; bus.rd_addr = 5'd3;
    endtask

    // Reference: value an instruction sees for a source register after bypassing.
    function automatic logic [31:0] model_fwd(input logic [4:0] addr, input logic [31:0] regv);
        if (addr == 0) return regv;
        if (bus.exdm_reg_write && bus.exdm_rd == addr) return bus.exdm_result;
        if (bus.dmwb_reg_write && bus.dmwb_rd == addr) return bus.dmwb_result;
        return regv;
    endfunction

    function automatic void model_alu(input logic [1:0] op, input logic [5:0] fn,
                                      input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] r, output logic ok);
        longint unsigned wide;
        ok = 1;
        r  = 0;
        wide = 64'(a) * 64'(b);
        if (op == 2'b00 || (op == 2'b10 && fn == 0)) r = a + b;
        else if (op == 2'b01 || (op == 2'b10 && fn == 1)) r = a - b;
        else if (op == 2'b10 && fn == 2) r = wide[31:0];
        else if (op == 2'b10 && fn == 3) r = a & b;
        else if (op == 2'b10 && fn == 4) r = a | b;
        else if (op == 2'b10 && fn == 5) r = (int'(a) < int'(b)) ? 1 : 0;
        else ok = 0;
    endfunction

    task automatic test_reset();
        clear_inputs();
        reset = 1;
        bus.in_valid = 1; bus.stall_in = 1; bus.flush = 1; bus.ctrl_in = 4'hf;
        bus.rs_data = $urandom; bus.imm = $urandom; bus.pc = $urandom;
        step();
        step();
        n_checks++;
        if ({bus.out_valid, bus.busy, bus.zero, bus.branch_taken, bus.ctrl_out, bus.rd_out}
            !== '0) begin
            n_fail++;
            $display("FAIL reset_flags: got v=%b b=%b z=%b t=%b c=%h rd=%0d, want all 0",
                     bus.out_valid, bus.busy, bus.zero, bus.branch_taken, bus.ctrl_out,
                     bus.rd_out);
        end
        n_checks++;
        if ((bus.result | bus.store_data | bus.branch_target) !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_data: got res=%h st=%h tgt=%h, want 0", bus.result,
                     bus.store_data, bus.branch_target);
        end
        clear_inputs();
        reset = 0;
        step();
    endtask

    task automatic test_addi();
        set_instr(AluAdd, 0, 1, 5, 0, 7);
        bus.rt_addr = 5'd8; bus.ctrl_in = 4'b0010;
        step();
        n_checks++;
        if ({bus.out_valid, bus.busy, bus.result, bus.rd_out, bus.ctrl_out} !==
            {1'b1, 1'b0, 32'd12, 5'd8, 4'b0010}) begin
            n_fail++;
            $display("FAIL addi: got v=%b busy=%b res=%0d rd=%0d ctrl=%b, want 1 0 12 8 0010",
                     bus.out_valid, bus.busy, bus.result, bus.rd_out, bus.ctrl_out);
        end
        bus.in_valid = 0;
        step();
        n_checks++;
        if ({bus.out_valid, bus.ctrl_out} !== 5'b0) begin
            n_fail++;
            $display("FAIL bubble: got v=%b ctrl=%b, want 0 0000", bus.out_valid, bus.ctrl_out);
        end
    endtask

    task automatic test_forwarding();
        // exdm wins over dmwb on a double match
        set_instr(AluRtype, FunctAdd, 0, 1, 2, 0);
        bus.rs_addr = 3; bus.rt_addr = 4;
        bus.exdm_reg_write = 1; bus.exdm_rd = 3; bus.exdm_result = 40;
        bus.dmwb_reg_write = 1; bus.dmwb_rd = 3; bus.dmwb_result = 99;
        step();
        n_checks++;
        if (bus.result !== 32'd42) begin
            n_fail++;
            $display("FAIL fwd_exdm: got %0d, want 42", bus.result);
        end
        // register zero never forwards
        set_instr(AluRtype, FunctAdd, 0, 0, 5, 0);
        bus.rs_addr = 0; bus.rt_addr = 4;
        bus.exdm_reg_write = 1; bus.exdm_rd = 0; bus.exdm_result = 40;
        bus.dmwb_reg_write = 1; bus.dmwb_rd = 0; bus.dmwb_result = 99;
        step();
        n_checks++;
        if (bus.result !== 32'd5) begin
            n_fail++;
            $display("FAIL fwd_r0: got %0d, want 5", bus.result);
        end
        // SW: store data takes forwarded rt even though operand B is imm
        set_instr(AluAdd, 0, 1, 100, 11, 4);
        bus.rt_addr = 6; bus.exdm_reg_write = 0; bus.exdm_rd = 6; bus.exdm_result = 55;
        bus.dmwb_reg_write = 1; bus.dmwb_rd = 6; bus.dmwb_result = 77;
        step();
        n_checks++;
        if ({bus.result, bus.store_data} !== {32'd104, 32'd77}) begin
            n_fail++;
            $display("FAIL fwd_store: got res=%0d st=%0d, want 104 77", bus.result,
                     bus.store_data);
        end
        bus.in_valid = 0;
        step();
    endtask

    task automatic test_branch();
        set_instr(AluSub, 0, 0, 9, 9, 8);
        bus.pc = 100; bus.branch = 1;
        step();
        n_checks++;
        if ({bus.zero, bus.branch_taken, bus.branch_target} !== {1'b1, 1'b1, 32'd108}) begin
            n_fail++;
            $display("FAIL beq_taken: got z=%b t=%b tgt=%0d, want 1 1 108", bus.zero,
                     bus.branch_taken, bus.branch_target);
        end
        bus.rt_data = 8;
        step();
        n_checks++;
        if ({bus.zero, bus.branch_taken, bus.branch_target} !== {1'b0, 1'b0, 32'd108}) begin
            n_fail++;
            $display("FAIL beq_not: got z=%b t=%b tgt=%0d, want 0 0 108", bus.zero,
                     bus.branch_taken, bus.branch_target);
        end
        bus.in_valid = 0;
        step();
    endtask

    task automatic test_reserved();
        logic [5:0] fn;
        set_instr(AluRsvd, 0, 0, 3, 4, 5);
        bus.ctrl_in = 4'b1111;
        step();
        n_checks++;
        if ({bus.out_valid, bus.result, bus.ctrl_out} !== {1'b1, 32'd0, 4'b1001}) begin
            n_fail++;
            $display("FAIL rsvd_op: got v=%b res=%0d ctrl=%b, want 1 0 1001", bus.out_valid,
                     bus.result, bus.ctrl_out);
        end
        fn = 6'($urandom_range(6, 63));
        set_instr(AluRtype, fn, 0, 3, 4, 5);
        bus.ctrl_in = 4'b0110;
        step();
        n_checks++;
        if ({bus.out_valid, bus.result, bus.ctrl_out} !== {1'b1, 32'd0, 4'b0000}) begin
            n_fail++;
            $display("FAIL bad_funct %0d: got v=%b res=%0d ctrl=%b, want 1 0 0000", fn,
                     bus.out_valid, bus.result, bus.ctrl_out);
        end
        bus.in_valid = 0;
        step();
    endtask

    task automatic test_mul();
        logic [31:0] a, b, exp;
        longint unsigned wide;
        for (int t = 0; t < 4; t++) begin
            a = (t == 0) ? 32'd6 : $urandom;
            b = (t == 0) ? 32'd7 : $urandom;
            wide = 64'(a) * 64'(b);
            exp = wide[31:0];
            set_instr(AluRtype, FunctMul, 0, a, b, 0);
            bus.ctrl_in = 4'b0010; bus.reg_dst = 1; bus.rd_addr = 9;
            for (int c = 1; c <= int'(MUL_LAT) + 1; c++) begin
                step();
                // operands change after acceptance; the captured ones must be used
                if (c == 1) begin
                    bus.rs_data = ~a; bus.rt_data = b + 1;
                end
                n_checks++;
                if ({bus.busy, bus.out_valid} !==
                    {(c <= int'(MUL_LAT)), (c == int'(MUL_LAT))}) begin
                    n_fail++;
                    $display("FAIL mul%0d cyc%0d: got busy=%b v=%b, want %b %b", t, c,
                             bus.busy, bus.out_valid, (c <= int'(MUL_LAT)),
                             (c == int'(MUL_LAT)));
                end
                if (c == int'(MUL_LAT)) begin
                    n_checks++;
                    if ({bus.result, bus.ctrl_out, bus.rd_out} !== {exp, 4'b0010, 5'd9}) begin
                        n_fail++;
                        $display("FAIL mul%0d result: got %h ctrl=%b rd=%0d, want %h 0010 9",
                                 t, bus.result, bus.ctrl_out, bus.rd_out, exp);
                    end
                end
            end
            bus.in_valid = 0;
            step();
        end
    endtask

    task automatic test_mul_stall();
        set_instr(AluRtype, FunctMul, 0, 5, 9, 0);
        step();
        bus.stall_in = 1;
        for (int c = 0; c < int'(MUL_LAT); c++) begin
            step();
            n_checks++;
            if ({bus.busy, bus.out_valid} !== 2'b10) begin
                n_fail++;
                $display("FAIL mul_stall cyc%0d: got busy=%b v=%b, want 1 0", c, bus.busy,
                         bus.out_valid);
            end
        end
        // counter ran out during the stall, so the result lands on the first free edge
        bus.stall_in = 0;
        step();
        n_checks++;
        if ({bus.busy, bus.out_valid, bus.result} !== {1'b1, 1'b1, 32'd45}) begin
            n_fail++;
            $display("FAIL mul_stall_done: got busy=%b v=%b res=%0d, want 1 1 45", bus.busy,
                     bus.out_valid, bus.result);
        end
        bus.stall_in = 1;
        step();
        n_checks++;
        if ({bus.busy, bus.out_valid, bus.result} !== {1'b1, 1'b1, 32'd45}) begin
            n_fail++;
            $display("FAIL mul_done_hold: got busy=%b v=%b res=%0d, want 1 1 45", bus.busy,
                     bus.out_valid, bus.result);
        end
        bus.stall_in = 0;
        step();
        bus.in_valid = 0;
        step();
    endtask

    task automatic test_stall();
        set_instr(AluAdd, 0, 1, 20, 0, 3);
        bus.ctrl_in = 4'b0010;
        step();
        set_instr(AluAdd, 0, 1, 50, 0, 1);
        bus.ctrl_in = 4'b0100; bus.stall_in = 1;
        for (int c = 0; c < 2; c++) begin
            step();
            n_checks++;
            if ({bus.out_valid, bus.result, bus.ctrl_out} !== {1'b1, 32'd23, 4'b0010}) begin
                n_fail++;
                $display("FAIL stall_hold%0d: got v=%b res=%0d ctrl=%b, want 1 23 0010", c,
                         bus.out_valid, bus.result, bus.ctrl_out);
            end
        end
        bus.stall_in = 0;
        step();
        n_checks++;
        if ({bus.out_valid, bus.result, bus.ctrl_out} !== {1'b1, 32'd51, 4'b0100}) begin
            n_fail++;
            $display("FAIL stall_release: got v=%b res=%0d ctrl=%b, want 1 51 0100",
                     bus.out_valid, bus.result, bus.ctrl_out);
        end
        set_instr(AluSub, 0, 0, 4, 4, 0);
        bus.branch = 1; bus.ctrl_in = 4'b0010; bus.stall_in = 1; bus.flush = 1;
        step();
        n_checks++;
        if ({bus.out_valid, bus.ctrl_out, bus.branch_taken} !== 6'b0) begin
            n_fail++;
            $display("FAIL flush_over_stall: got v=%b ctrl=%b t=%b, want 0 0000 0",
                     bus.out_valid, bus.ctrl_out, bus.branch_taken);
        end
        clear_inputs();
        step();
    endtask

    task automatic test_flush_mul();
        set_instr(AluRtype, FunctMul, 0, 12, 3, 0);
        bus.ctrl_in = 4'b0010;
        step();
        bus.flush = 1;
        step();
        n_checks++;
        if ({bus.busy, bus.out_valid, bus.ctrl_out, bus.branch_taken} !== 7'b0) begin
            n_fail++;
            $display("FAIL flush_mul: got busy=%b v=%b ctrl=%b t=%b, want 0 0 0000 0",
                     bus.busy, bus.out_valid, bus.ctrl_out, bus.branch_taken);
        end
        clear_inputs();
        for (int c = 0; c <= int'(MUL_LAT); c++) begin
            step();
            n_checks++;
            if ({bus.busy, bus.out_valid} !== 2'b00) begin
                n_fail++;
                $display("FAIL flush_late%0d: got busy=%b v=%b, want 0 0", c, bus.busy,
                         bus.out_valid);
            end
        end
    endtask

    task automatic test_reset_mid_mul();
        set_instr(AluRtype, FunctMul, 0, 8, 8, 0);
        bus.ctrl_in = 4'b0010;
        step();
        bus.stall_in = 1; reset = 1;
        step();
        n_checks++;
        if ({bus.busy, bus.out_valid, bus.ctrl_out, bus.rd_out, bus.result,
             bus.branch_taken} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_mul: got busy=%b v=%b ctrl=%b rd=%0d res=%0d, want 0",
                     bus.busy, bus.out_valid, bus.ctrl_out, bus.rd_out, bus.result);
        end
        reset = 0;
        clear_inputs();
        for (int c = 0; c <= int'(MUL_LAT); c++) begin
            step();
            n_checks++;
            if ({bus.busy, bus.out_valid} !== 2'b00) begin
                n_fail++;
                $display("FAIL reset_late%0d: got busy=%b v=%b, want 0 0", c, bus.busy,
                         bus.out_valid);
            end
        end
        set_instr(AluRtype, FunctAdd, 0, 3, 4, 0);
        step();
        n_checks++;
        if ({bus.out_valid, bus.result} !== {1'b1, 32'd7}) begin
            n_fail++;
            $display("FAIL add_after_reset: got v=%b res=%0d, want 1 7", bus.out_valid,
                     bus.result);
        end
        bus.in_valid = 0;
        step();
    endtask

    task automatic test_random();
        logic [31:0] a, rt, b, r;
        logic        ok, v, tk;
        logic [3:0]  ct;
        logic [4:0]  rd;
        logic [31:0] tgt;
        for (int i = 0; i < 60; i++) begin
            clear_inputs();
            v = ($urandom_range(0, 4) != 0);
            bus.in_valid = v;
            bus.alu_op = 2'($urandom_range(0, 3));
            bus.funct = ($urandom_range(0, 5) == 0) ? 6'($urandom_range(6, 63))
                                                    : 6'($urandom_range(0, 5));
            if (bus.alu_op == 2'b10 && bus.funct == 6'd2) bus.funct = 6'd5;
            bus.alu_src = 1'($urandom); bus.reg_dst = 1'($urandom); bus.branch = 1'($urandom);
            bus.ctrl_in = 4'($urandom);
            bus.pc = $urandom; bus.imm = ($urandom_range(0, 1) != 0) ? $urandom : 32'hffff_fff0;
            bus.rs_data = $urandom; bus.rt_data = $urandom;
            if ($urandom_range(0, 3) == 0) bus.rt_data = bus.rs_data;
            bus.rs_addr = 5'($urandom_range(0, 3)); bus.rt_addr = 5'($urandom_range(0, 3));
            bus.rd_addr = 5'($urandom);
            bus.exdm_reg_write = 1'($urandom); bus.exdm_rd = 5'($urandom_range(0, 3));
            bus.dmwb_reg_write = 1'($urandom); bus.dmwb_rd = 5'($urandom_range(0, 3));
            bus.exdm_result = $urandom; bus.dmwb_result = $urandom;

            a  = model_fwd(bus.rs_addr, bus.rs_data);
            rt = model_fwd(bus.rt_addr, bus.rt_data);
            b  = (bus.alu_src || bus.alu_op == 2'b00) ? bus.imm : rt;
            model_alu(bus.alu_op, bus.funct, a, b, r, ok);
            ct  = !v ? 4'b0 : (ok ? bus.ctrl_in : (bus.ctrl_in & 4'b1001));
            tk  = v & bus.branch & (a == b);
            rd  = bus.reg_dst ? bus.rd_addr : bus.rt_addr;
            tgt = bus.pc + bus.imm;
            step();
            n_checks++;
            if ({bus.out_valid, bus.ctrl_out, bus.busy} !== {v, ct, 1'b0}) begin
                n_fail++;
                $display("FAIL rand%0d ctl: got v=%b ctrl=%b busy=%b, want %b %b 0", i,
                         bus.out_valid, bus.ctrl_out, bus.busy, v, ct);
            end
            if (v) begin
                n_checks++;
                if ({bus.result, bus.store_data, bus.zero, bus.branch_taken, bus.rd_out,
                     bus.branch_target} !== {r, rt, (a == b), tk, rd, tgt}) begin
                    n_fail++;
                    $display("FAIL rand%0d data op=%b fn=%0d: got res=%h st=%h z=%b t=%b rd=%0d tgt=%h, want %h %h %b %b %0d %h",
                             i, bus.alu_op, bus.funct, bus.result, bus.store_data, bus.zero,
                             bus.branch_taken, bus.rd_out, bus.branch_target, r, rt, (a == b),
                             tk, rd, tgt);
                end
            end
        end
        clear_inputs();
        step();
    endtask

    initial begin
        clk = 0;
        reset = 1;
        n_checks = 0;
        n_fail = 0;
        test_reset();
        test_addi();
        test_forwarding();
        test_branch();
        test_reserved();
        test_mul();
        test_mul_stall();
        test_stall();
        test_flush_mul();
        test_reset_mid_mul();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
